// File: rtl/otsu_histograma_varredura.sv
// otsu_histograma_varredura: per-frame grey-level histogram capture and cumulative level sweep.
module otsu_histograma_varredura #(
  parameter int MN      = 307200,
  parameter int W_OMEGA = 19,
  parameter int W_MI    = 27
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [7:0]         iPix,
  input  logic               iPixValid,
  output logic               oPronto,
  output logic [7:0]         oNivel,
  output logic [W_OMEGA-1:0] oOmega0,
  output logic [W_MI-1:0]    oMi0,
  output logic [W_MI-1:0]    oMiT,
  output logic               oAtiva,
  output logic               oFim
);
  typedef enum logic [1:0] {CLEAR, CAPTURE, FLUSH, SWEEP} state_t;
  state_t state, nxt;
  logic [W_OMEGA-1:0] mem [256];
  logic [W_OMEGA-1:0] rd_q, wc, inc, wd, cnt;
  logic [W_MI-1:0]    mit;
  logic [8:0]         rk;
  logic [7:0]         cc, p1, wp, k1, wa, ra;
  logic               v1, wv, sv, we, acc, rd_en;
  assign oPronto = state == CAPTURE;
  assign acc     = oPronto && iPixValid;
  assign rd_en   = state == SWEEP && !rk[8];
  assign ra      = rd_en ? rk[7:0] : iPix;
  // the write issued last cycle is not yet visible in rd_q, so forward it
  assign inc     = ((wv && wp == p1) ? wc : rd_q) + W_OMEGA'(1);
  always_comb begin
    nxt = state;
    we  = v1;
    wa  = p1;
    wd  = inc;
    case (state)
      CLEAR: begin
        we = 1'b1;
        wa = cc;
        wd = '0;
        nxt = cc == 8'd255 ? CAPTURE : CLEAR;
      end
      CAPTURE: nxt = (acc && cnt == W_OMEGA'(MN - 1)) ? FLUSH : CAPTURE;
      FLUSH:   nxt = v1 ? FLUSH : SWEEP;
      SWEEP: begin
        we = rd_en;
        wa = rk[7:0];
        wd = '0;
        nxt = (sv && k1 == 8'd255) ? CAPTURE : SWEEP;
      end
      default: nxt = CLEAR;
    endcase
  end
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) state <= CLEAR;
    else state <= nxt;
  // sweep reads clear each bin as it goes, so the next frame starts from zero
  always_ff @(posedge iClk) begin
    if (we) mem[wa] <= wd;
    rd_q <= mem[ra];
  end
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      cc      <= '0;
      v1      <= 1'b0;
      p1      <= '0;
      wv      <= 1'b0;
      wp      <= '0;
      wc      <= '0;
      cnt     <= '0;
      mit     <= '0;
      rk      <= '0;
      sv      <= 1'b0;
      k1      <= '0;
      oAtiva  <= 1'b0;
      oFim    <= 1'b0;
      oNivel  <= '0;
      oOmega0 <= '0;
      oMi0    <= '0;
      oMiT    <= '0;
    end else begin
      cc <= state == CLEAR ? cc + 8'd1 : 8'd0;
      v1 <= acc;
      p1 <= iPix;
      wv <= v1;
      wp <= p1;
      wc <= inc;
      if (acc) begin
        cnt <= cnt + W_OMEGA'(1);
        mit <= mit + W_MI'(iPix);
      end
      rk     <= state == SWEEP ? rk + {8'd0, rd_en} : 9'd0;
      sv     <= rd_en;
      k1     <= rk[7:0];
      oAtiva <= sv;
      oFim   <= oAtiva && oNivel == 8'd255;
      if (sv) begin
        oNivel  <= k1;
        oOmega0 <= (k1 == 8'd0 ? '0 : oOmega0) + rd_q;
        oMi0    <= (k1 == 8'd0 ? '0 : oMi0) + W_MI'(k1) * W_MI'(rd_q);
        oMiT    <= mit;
      end
      if (sv && k1 == 8'd255) begin
        cnt <= '0;
        mit <= '0;
      end
    end
endmodule

// File: tb/tb_otsu_histograma_varredura.sv
// tb_otsu_histograma_varredura: directed frames with a queued per-level scoreboard.
module tb_otsu_histograma_varredura;
  localparam int MN = 16;
  logic        iClk = 1'b0, iRst = 1'b1;
  logic [7:0]  iPix = '0;
  logic        iPixValid = 1'b0;
  logic        oPronto, oAtiva, oFim;
  logic [7:0]  oNivel;
  logic [18:0] oOmega0;
  logic [26:0] oMi0, oMiT;
  typedef struct {logic [7:0] k; logic [18:0] om; logic [26:0] mi; logic [26:0] mt;} exp_t;
  exp_t q[$];
  int   vectors = 0, miscompares = 0;
  bit   mon_en = 1'b0, exp_fim = 1'b0;
  logic [7:0] fr [MN];

  otsu_histograma_varredura #(.MN(MN), .W_OMEGA(19), .W_MI(27)) dut (
    .iClk(iClk), .iRst(iRst), .iPix(iPix), .iPixValid(iPixValid), .oPronto(oPronto),
    .oNivel(oNivel), .oOmega0(oOmega0), .oMi0(oMi0), .oMiT(oMiT), .oAtiva(oAtiva), .oFim(oFim)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge iClk)
    if (mon_en && !iRst) begin
      if (exp_fim) begin
        chk("fim", 64'(oFim), 64'd1);
        exp_fim = 1'b0;
      end else if (oFim) begin
        vectors++;
        miscompares++;
        $display("FAIL fim_spurious: got 1 expected 0");
      end
      if (oAtiva) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL ativa_unexpected: got nivel %0d expected no output", oNivel);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("nivel", 64'(oNivel), 64'(e.k));
          chk($sformatf("omega0[k=%0d]", e.k), 64'(oOmega0), 64'(e.om));
          chk($sformatf("mi0[k=%0d]", e.k), 64'(oMi0), 64'(e.mi));
          chk($sformatf("miT[k=%0d]", e.k), 64'(oMiT), 64'(e.mt));
          if (e.k == 8'd255) exp_fim = 1'b1;
        end
      end
    end

  task automatic push_frame();
    int h[256];
    int om = 0, mi = 0, mt = 0;
    for (int i = 0; i < 256; i++) h[i] = 0;
    for (int i = 0; i < MN; i++) begin
      h[fr[i]]++;
      mt += fr[i];
    end
    for (int k = 0; k < 256; k++) begin
      om += h[k];
      mi += k * h[k];
      q.push_back('{8'(k), 19'(om), 27'(mi), 27'(mt)});
    end
  endtask

  task automatic wait_pronto();
    int n = 0;
    while (!oPronto && n < 2000) begin
      @(posedge iClk); #1;
      n++;
    end
    if (!oPronto) begin
      vectors++;
      miscompares++;
      $display("FAIL pronto_timeout: got 0 expected 1");
    end
  endtask

  task automatic send_frame(input bit gaps);
    wait_pronto();
    push_frame();
    for (int i = 0; i < MN; i++) begin
      if (gaps && i % 3 == 1) begin
        iPixValid = 1'b0;
        @(posedge iClk); #1;
      end
      iPix = fr[i];
      iPixValid = 1'b1;
      @(posedge iClk); #1;
    end
    iPixValid = 1'b0;
  endtask

  task automatic junk(input logic [7:0] v);
    for (int i = 0; i < 12; i++) begin
      iPix = v;
      iPixValid = 1'b1;
      @(posedge iClk); #1;
    end
    iPixValid = 1'b0;
  endtask

  task automatic reset_and_clear();
    int n = 0;
    bit seen = 1'b0;
    #1;
    chk("reset_flags", 64'({oPronto, oAtiva, oFim, oNivel}), 64'd0);
    chk("reset_sums", 64'({oOmega0, oMi0}), 64'd0);
    chk("reset_mit", 64'(oMiT), 64'd0);
    @(posedge iClk); #1;
    iRst = 1'b0;
    while (!oPronto && n < 400) begin
      @(posedge iClk); #1;
      n++;
      seen |= oAtiva;
    end
    chk("clear_cycles", 64'(n), 64'd256);
    chk("ativa_in_clear", 64'(seen), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || exp_fim) && n < 2000) begin
      @(posedge iClk); #1;
      n++;
    end
    if (q.size() != 0 || exp_fim) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
      exp_fim = 1'b0;
    end
  endtask

  initial begin
    #12;
    reset_and_clear();
    mon_en = 1'b1;
    for (int i = 0; i < MN; i++) fr[i] = 8'd100;
    send_frame(1'b0);
    junk(8'd100);
    fr = '{8'd5, 8'd5, 8'd7, 8'd5, 8'd7, 8'd7, 8'd5, 8'd7, 8'd5, 8'd5, 8'd7, 8'd7, 8'd5, 8'd7, 8'd7, 8'd5};
    send_frame(1'b0);
    for (int i = 0; i < MN; i++) fr[i] = 8'd3;
    send_frame(1'b0);
    junk(8'd3);
    for (int i = 0; i < MN; i++) fr[i] = 8'd200;
    send_frame(1'b1);
    fr = '{8'd0, 8'd255, 8'd0, 8'd1, 8'd128, 8'd255, 8'd254, 8'd2, 8'd0, 8'd255, 8'd17, 8'd17, 8'd17, 8'd200, 8'd1, 8'd255};
    send_frame(1'b1);
    drain();
    for (int i = 0; i < MN; i++) fr[i] = 8'd42;
    send_frame(1'b0);
    begin
      int n = 0;
      while (!(oAtiva && oNivel == 8'd120) && n < 2000) begin
        @(posedge iClk); #2;
        n++;
      end
      chk("reached_k120", 64'(oNivel), 64'd120);
    end
    mon_en = 1'b0;
    iRst = 1'b1;
    q.delete();
    exp_fim = 1'b0;
    reset_and_clear();
    mon_en = 1'b1;
    for (int i = 0; i < MN; i++) fr[i] = 8'd255;
    send_frame(1'b0);
    drain();
    repeat (4) @(posedge iClk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
